// File: rtl/button_debounce_pkg.sv
// Shared constants and types for the board button / LED user-interface blocks.
//   state_t          debouncer FSM states
//   CLK_HZ           board oscillator frequency
//   DEF_*_CYCLES     default debounce / first-repeat / repeat-interval cycle counts
//   max2()           helper for sizing counters from several parameters
package button_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;  // 20 ms
  localparam int unsigned DEF_HOLD_CYCLES     = CLK_HZ / 2;   // 0.5 s
  localparam int unsigned DEF_REPEAT_CYCLES   = CLK_HZ / 10;  // 100 ms

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button conditioning bundle: raw pin in, debounced level and strobes out.
//   btn_in         raw asynchronous pin
//   btn_level      debounced level, 1 = pressed
//   press_pulse    one-cycle strobe on accepted press
//   release_pulse  one-cycle strobe on accepted release
//   repeat_pulse   one-cycle strobe per auto-repeat while held
// master: the side driving the pin and consuming the strobes; slave: the debouncer.
interface button_debounce_if;

  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, repeat_pulse
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, repeat_pulse
  );

endinterface

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk   destination clock
//   rst   synchronous, active-high reset; both flops load RESET_VAL
//   d     asynchronous input
//   q     synchronised output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Conditions one raw board pushbutton: polarity fix, 2-flop synchroniser,
// debounce FSM, single-cycle press/release strobes and held-key auto-repeat.
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   slave side of button_debounce_if (btn_in in; btn_level and strobes out)
// Parameters: DEBOUNCE_CYCLES (>=2) stable cycles before a level is accepted,
// HOLD_CYCLES (>=1) from press to first repeat, REPEAT_CYCLES between later
// repeats (0 = single repeat only), ACTIVE_LOW pin polarity.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input logic              clk,
  input logic              rst,
  button_debounce_if.slave bus
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RW = $clog2(max2(max2(HOLD_CYCLES, REPEAT_CYCLES), 2));

  localparam logic [DW-1:0] D_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] H_LAST    = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST    = RW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam bit            REPEAT_EN = (REPEAT_CYCLES != 0);

  logic          pin_pressed;
  logic          btn_s;
  state_t        state;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  logic          first_rep;
  logic          level;
  logic          press;
  logic          release_s;
  logic          repeat_s;

  // Polarity is folded in ahead of the synchroniser so both flops reset to
  // the released level (0) regardless of ACTIVE_LOW.
  assign pin_pressed = ACTIVE_LOW ? ~bus.btn_in : bus.btn_in;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin_pressed),
    .q   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dcnt      <= '0;
      rcnt      <= '0;
      first_rep <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      release_s <= 1'b0;
      repeat_s  <= 1'b0;
    end else begin
      press     <= 1'b0;
      release_s <= 1'b0;
      repeat_s  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (dcnt == D_LAST) begin
            state     <= PRESSED;
            press     <= 1'b1;
            level     <= 1'b1;
            rcnt      <= '0;
            first_rep <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            // rcnt is left untouched so a release bounce resumes the hold timer
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end else if (first_rep && rcnt == H_LAST) begin
            repeat_s  <= 1'b1;
            rcnt      <= '0;
            first_rep <= 1'b0;
          end else if (!first_rep && REPEAT_EN && rcnt == R_LAST) begin
            repeat_s <= 1'b1;
            rcnt     <= '0;
          end else if (rcnt != '1) begin
            rcnt <= rcnt + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= PRESSED;
          end else if (dcnt == D_LAST) begin
            state     <= IDLE;
            release_s <= 1'b1;
            level     <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.btn_level     = level;
  assign bus.press_pulse   = press;
  assign bus.release_pulse = release_s;
  assign bus.repeat_pulse  = repeat_s;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20,
// REPEAT_CYCLES=8, ACTIVE_LOW=1. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 time unit after the next rising edge.
module tb_button_debounce;

  localparam int unsigned D = 4;
  localparam int unsigned H = 20;
  localparam int unsigned R = 8;

  typedef int iq_t[$];
  typedef struct packed {
    logic       rst;
    logic       pin;
    logic [3:0] exp;  // {btn_level, press, release, repeat}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int level_hi = 0;
  logic [3:0] obs;
  iq_t press_q, rel_q, rep_q;
  vec_t tbl[23];

  button_debounce_if bus();

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic p);
    rst = r;
    bus.btn_in = p;
    @(posedge clk);
    #1;
    cyc++;
    obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.repeat_pulse};
    if (obs[3]) level_hi++;
    if (obs[2]) press_q.push_back(cyc);
    if (obs[1]) rel_q.push_back(cyc);
    if (obs[0]) rep_q.push_back(cyc);
    checks++;
    if ($countones(obs[2:0]) > 1) begin
      failures++;
      $display("FAIL strobe_exclusive cyc=%0d: strobes=%b required at most one set", cyc, obs[2:0]);
    end
  endtask

  task automatic clear_log();
    press_q.delete();
    rel_q.delete();
    rep_q.delete();
    level_hi = 0;
  endtask

  task automatic check_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic iq_t rel(input iq_t q, input int base);
    iq_t r;
    foreach (q[i]) r.push_back(q[i] - base);
    return r;
  endfunction

  task automatic check_q(input string name, input iq_t got, input iq_t exp);
    bit ok;
    string gs, es;
    checks++;
    ok = (got.size() == exp.size());
    if (ok) foreach (got[i]) if (got[i] != exp[i]) ok = 1'b0;
    if (!ok) begin
      failures++;
      gs = "";
      es = "";
      foreach (got[i]) if (i < 16) gs = {gs, $sformatf(" %0d", got[i])};
      foreach (exp[i]) es = {es, $sformatf(" %0d", exp[i])};
      $display("FAIL %s: got {%s } required {%s }", name, gs, es);
    end
  endtask

  task automatic wait_press(input string name, input int e0, output int p);
    p = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      if (press_q.size() != 0) begin
        p = press_q[0];
        break;
      end
    end
    check_eq(name, p - e0, 6);
  endtask

  initial begin
    int e0, p, p2, a, r0;
    iq_t exp_q;

    // Reset, idle, one clean press of 10 samples, clean release.
    for (int i = 0; i < 23; i++) begin
      tbl[i].rst = (i < 3);
      tbl[i].pin = (i >= 5 && i <= 14) ? 1'b0 : 1'b1;
      tbl[i].exp = (i >= 11 && i <= 20) ? 4'b1000 : 4'b0000;
    end
    tbl[11].exp = 4'b1100;
    tbl[21].exp = 4'b0010;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst, tbl[i].pin);
      checks++;
      if (obs !== tbl[i].exp) begin
        failures++;
        $display("FAIL vec[%0d]: outputs=%b required %b", i, obs, tbl[i].exp);
      end
    end

    // 50 idle cycles: nothing.
    clear_log();
    repeat (50) step(1'b0, 1'b1);
    check_eq("idle_strobes", press_q.size() + rel_q.size() + rep_q.size(), 0);
    check_eq("idle_level", level_hi, 0);

    // Bounce every 2 samples: never accepted.
    clear_log();
    for (int i = 0; i < 30; i++) step(1'b0, ((i / 2) % 2 == 1) ? 1'b1 : 1'b0);
    repeat (10) step(1'b0, 1'b1);
    check_eq("bounce_press", press_q.size(), 0);
    check_eq("bounce_level", level_hi, 0);

    // Long hold: first repeat after HOLD, then every REPEAT.
    clear_log();
    e0 = cyc + 1;
    wait_press("hold_press_latency", e0, p);
    while (cyc < p + 59) step(1'b0, 1'b0);
    exp_q = '{20, 28, 36, 44, 52};
    check_q("hold_repeats", rel(rep_q, p), exp_q);
    check_eq("hold_release", rel_q.size(), 0);

    // Release with one-sample glitch back to pressed.
    a = cyc + 1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    exp_q = '{9};
    check_q("glitch_release", rel(rel_q, a), exp_q);
    exp_q = '{20, 28, 36, 44, 52, 60};
    check_q("glitch_repeats", rel(rep_q, p), exp_q);
    check_eq("glitch_press_count", press_q.size(), 1);
    check_eq("glitch_level_end", int'(obs[3]), 0);

    // One-sample release bounce mid-hold: hold timer resumes (first repeat +22).
    clear_log();
    e0 = cyc + 1;
    wait_press("resume_press_latency", e0, p2);
    while (cyc < p2 + 32) step(1'b0, (cyc + 1 == p2 + 5) ? 1'b1 : 1'b0);
    exp_q = '{22, 30};
    check_q("resume_repeats", rel(rep_q, p2), exp_q);
    check_eq("resume_release", rel_q.size(), 0);
    check_eq("resume_level_cycles", level_hi, 33);

    clear_log();
    a = cyc + 1;
    repeat (12) step(1'b0, 1'b1);
    exp_q = '{6};
    check_q("resume_release_pulse", rel(rel_q, a), exp_q);
    check_eq("resume_release_repeats", rep_q.size(), 0);

    // Reset at dcnt==2 of PRESS_WAIT with pin held.
    clear_log();
    repeat (5) step(1'b0, 1'b0);
    r0 = cyc + 1;
    step(1'b1, 1'b0);
    check_eq("rst_pw_outputs", int'(obs), 0);
    while (cyc < r0 + 10) step(1'b0, 1'b0);
    exp_q = '{7};
    check_q("rst_pw_press", rel(press_q, r0), exp_q);

    // Reset while pressed: level drops, fresh press reported.
    clear_log();
    r0 = cyc + 1;
    step(1'b1, 1'b0);
    check_eq("rst_pressed_outputs", int'(obs), 0);
    while (cyc < r0 + 10) step(1'b0, 1'b0);
    exp_q = '{7};
    check_q("rst_pressed_press", rel(press_q, r0), exp_q);
    check_eq("rst_pressed_release", rel_q.size(), 0);

    clear_log();
    a = cyc + 1;
    repeat (10) step(1'b0, 1'b1);
    exp_q = '{6};
    check_q("final_release", rel(rel_q, a), exp_q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
